// File: rtl/fb_write_scheduler_pkg.sv
// Shared types and helpers for the frame-buffer write scheduler.
package fb_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_SWAP = 2'd2
    } sched_state_t;

    function automatic int pixel_addr_width(input int h, input int v);
        return $clog2(h * v);
    endfunction

    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_write_scheduler_if.sv
// Requester-side handshake plus frame-buffer write port of the scheduler.
interface fb_write_scheduler_if #(
    parameter int NUM_REQ          = 2,
    parameter int PIXEL_ADDR_WIDTH = 19,
    parameter int OWNER_WIDTH      = 1
);
    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0]                  req_ready;
    logic [NUM_REQ*PIXEL_ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]                  req_data;
    logic [NUM_REQ-1:0]                  req_last;
    logic                                wr_en;
    logic [PIXEL_ADDR_WIDTH-1:0]         wr_addr;
    logic                                wr_data;
    logic [OWNER_WIDTH-1:0]              owner;
    logic                                busy;

    modport master (
        output req_valid, req_addr, req_data, req_last,
        input  req_ready, wr_en, wr_addr, wr_data, owner, busy
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_last,
        output req_ready, wr_en, wr_addr, wr_data, owner, busy
    );
endinterface

// File: rtl/fb_write_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr.
// Latency: 0 cycles. Backpressure: none, pure function of its inputs.
// Arbitration start point is owned by the caller.
module rr_arbiter #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         any_grant,
    output logic [W-1:0] grant
);
    int idx;

    // Scan from farthest to nearest so the nearest asserted request wins.
    always_comb begin
        any_grant = 1'b0;
        grant     = '0;
        idx       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                any_grant = 1'b1;
                grant     = W'(idx);
            end
        end
    end
endmodule

// File: rtl/fb_write_scheduler.sv
// Frame-granular owner of the frame-buffer write port; optional FB_SCHED_STATS_EN adds late_frames.
// Latency: accepted write appears on wr_* one cycle later; grant takes one IDLE cycle.
// Backpressure: only the owner sees req_ready (=ce) in GRANT; others held off until the next frame.
module fb_write_scheduler
    import fb_sched_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int NUM_REQ           = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  swap,
    fb_write_scheduler_if.slave   bus
`ifdef FB_SCHED_STATS_EN
    ,
    output logic [15:0]           late_frames
`endif
);
    localparam int PIXEL_ADDR_WIDTH = pixel_addr_width(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS);
    localparam int OWNER_WIDTH      = owner_width(NUM_REQ);

    sched_state_t                state;
    logic [OWNER_WIDTH-1:0]      owner_q;
    logic [OWNER_WIDTH-1:0]      rr_ptr;
    logic [OWNER_WIDTH-1:0]      rr_next;
    logic                        wr_en_q;
    logic [PIXEL_ADDR_WIDTH-1:0] wr_addr_q;
    logic                        wr_data_q;
    logic                        arb_any;
    logic [OWNER_WIDTH-1:0]      arb_grant;

    rr_arbiter #(.N(NUM_REQ), .W(OWNER_WIDTH)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .any_grant (arb_any),
        .grant     (arb_grant)
    );

    // Next search starts just past the requester that was granted.
    always_comb begin
        rr_next = '0;
        if (arb_grant != OWNER_WIDTH'(NUM_REQ - 1))
            rr_next = arb_grant + 1'b1;
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == GRANT && ce)
            bus.req_ready[owner_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_q   <= '0;
            rr_ptr    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    wr_en_q <= 1'b0;
                    if (arb_any) begin
                        owner_q <= arb_grant;
                        rr_ptr  <= rr_next;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    // A swap here is ignored: the write of an accepted last lands after it.
                    wr_en_q <= bus.req_valid[owner_q];
                    if (bus.req_valid[owner_q]) begin
                        wr_addr_q <= bus.req_addr[owner_q*PIXEL_ADDR_WIDTH +: PIXEL_ADDR_WIDTH];
                        wr_data_q <= bus.req_data[owner_q];
                        if (bus.req_last[owner_q])
                            state <= WAIT_SWAP;
                    end
                end
                WAIT_SWAP: begin
                    wr_en_q <= 1'b0;
                    if (swap)
                        state <= IDLE;
                end
                default: begin
                    wr_en_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef FB_SCHED_STATS_EN
    // Counts frames whose producer was still writing when the display swapped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            late_frames <= 16'd0;
        else if (ce && state == GRANT && swap && late_frames != 16'hFFFF)
            late_frames <= late_frames + 16'd1;
    end
`endif

    assign bus.wr_en   = wr_en_q & ce;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_fb_write_scheduler.sv
// Scoreboard-based bench for fb_write_scheduler (two requesters).
module tb_fb_write_scheduler;
    import fb_sched_pkg::*;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int N  = 2;
    localparam int AW = pixel_addr_width(H, V);
    localparam int OW = owner_width(N);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic ce;
    logic swap;

    always #5 clk = ~clk;

    fb_write_scheduler_if #(.NUM_REQ(N), .PIXEL_ADDR_WIDTH(AW), .OWNER_WIDTH(OW)) bus ();

`ifdef FB_SCHED_STATS_EN
    logic [15:0] late_frames;
`endif

    fb_write_scheduler #(
        .HOR_ACTIVE_PIXELS (H),
        .VER_ACTIVE_PIXELS (V),
        .NUM_REQ           (N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .swap        (swap),
        .bus         (bus.slave)
`ifdef FB_SCHED_STATS_EN
        ,
        .late_frames (late_frames)
`endif
    );

    int  checks = 0;
    int  errors = 0;
    int  wr_seen = 0;
    wr_t exp_q[$];

    // Pop one expected write per observed wr_en, then record beats accepted at the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_en) begin
                wr_t e;
                wr_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_write: got addr=%0d data=%0b, expected none",
                             bus.wr_addr, bus.wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.wr_addr, bus.wr_data} !== {e.addr, e.data}) begin
                        errors++;
                        $display("FAIL sb_write: got addr=%0d data=%0b, expected addr=%0d data=%0b",
                                 bus.wr_addr, bus.wr_data, e.addr, e.data);
                    end
                end
            end
            for (int i = 0; i < N; i++)
                if (bus.req_valid[i] && bus.req_ready[i])
                    exp_q.push_back({bus.req_addr[i*AW +: AW], bus.req_data[i]});
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_swap();
        swap = 1'b1;
        tick();
        swap = 1'b0;
    endtask

    // Present one beat and hold it until the scheduler takes it.
    task automatic drive_beat(input int i, input int addr, input logic d, input logic last);
        int n = 0;
        bus.req_valid[i]          = 1'b1;
        bus.req_addr[i*AW +: AW]  = AW'(addr);
        bus.req_data[i]           = d;
        bus.req_last[i]           = last;
        forever begin
            @(negedge clk);
            if (bus.req_ready[i]) break;
            n++;
            if (n >= 200) break;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL beat_timeout: req %0d addr %0d never ready, expected ready within 200 cycles", i, addr);
        end
        tick();
    endtask

    task automatic check_drained(input string name);
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d writes outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; swap = 1'b0;
        bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0; bus.req_last = '0;
        #12;
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.req_ready, bus.owner, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: wr_en=%0b wr_addr=%0d wr_data=%0b ready=%b owner=%0d busy=%0b, expected all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.req_ready, bus.owner, bus.busy);
        end
        bus.req_valid = 2'b11;
        bus.req_addr[0 +: AW]  = AW'(0);
        bus.req_data[0]        = 1'b1;
        bus.req_addr[AW +: AW] = AW'(100);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: busy=%0b ready=%b, expected busy=0 ready=00", bus.busy, bus.req_ready);
        end
        tick();
    endtask

    task automatic test_frame_grant();
        logic [3:0] pat;
        pat = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            bus.req_addr[0 +: AW] = AW'(k);
            bus.req_data[0]       = pat[k];
            bus.req_last[0]       = (k == 3);
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b1 || bus.owner !== 1'b0 || bus.req_ready !== 2'b01) begin
                errors++;
                $display("FAIL grant_beat%0d: busy=%0b owner=%0d ready=%b, expected busy=1 owner=0 ready=01",
                         k, bus.busy, bus.owner, bus.req_ready);
            end
            checks++;
            if (bus.wr_en !== (k > 0) ||
                (k > 0 && (bus.wr_addr !== AW'(k - 1) || bus.wr_data !== pat[k-1]))) begin
                errors++;
                $display("FAIL grant_write%0d: wr_en=%0b addr=%0d data=%0b, expected wr_en=%0b addr=%0d",
                         k, bus.wr_en, bus.wr_addr, bus.wr_data, (k > 0), (k > 0) ? k - 1 : 0);
            end
            tick();
        end
        bus.req_valid[0] = 1'b0;
        bus.req_last[0]  = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== AW'(3) || bus.wr_data !== 1'b1 || bus.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL grant_last_write: wr_en=%0b addr=%0d data=%0b ready=%b, expected 1/3/1/00",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.req_ready);
        end
        tick();
    endtask

    task automatic test_wait_swap_rr();
        int bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.wr_en, bus.busy, bus.req_ready} !== 4'b0100) begin
                errors++; bad++;
                if (bad < 4)
                    $display("FAIL wait_swap_hold cycle %0d: wr_en=%0b busy=%0b ready=%b, expected 0/1/00",
                             c, bus.wr_en, bus.busy, bus.req_ready);
            end
            tick();
        end
        pulse_swap();
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL swap_release: busy=%0b, expected 0", bus.busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.owner !== 1'b1 || bus.req_ready !== 2'b10) begin
            errors++;
            $display("FAIL rr_owner: owner=%0d ready=%b, expected owner=1 ready=10", bus.owner, bus.req_ready);
        end
        tick();
        drive_beat(1, 101, 1'b1, 1'b0);
        drive_beat(1, 102, 1'b0, 1'b0);
        drive_beat(1, 103, 1'b1, 1'b1);
        bus.req_valid[1] = 1'b0;
        bus.req_last[1]  = 1'b0;
        check_drained("rr_frame");
    endtask

    task automatic test_swap_with_last();
        bus.req_valid[0]      = 1'b1;
        bus.req_addr[0 +: AW] = AW'(200);
        pulse_swap();
        tick();
        @(negedge clk);
        checks++;
        if (bus.owner !== 1'b0 || bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rr_back_to_0: owner=%0d ready=%b, expected owner=0 ready=01", bus.owner, bus.req_ready);
        end
        tick();
        drive_beat(0, 201, 1'b0, 1'b0);
        swap = 1'b1;
        drive_beat(0, 202, 1'b1, 1'b1);
        swap = 1'b0;
        bus.req_valid[0] = 1'b0;
        bus.req_last[0]  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b1 || bus.req_ready !== 2'b00) begin
                errors++;
                $display("FAIL coincident_swap_hold cycle %0d: busy=%0b ready=%b, expected busy=1 ready=00",
                         c, bus.busy, bus.req_ready);
            end
            tick();
        end
        pulse_swap();
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL second_swap_release: busy=%0b, expected 0", bus.busy);
        end
        check_drained("coincident");
    endtask

    task automatic test_ce_stall();
        int base;
        base = wr_seen;
        drive_beat(1, 300, 1'b1, 1'b0);
        drive_beat(1, 301, 1'b0, 1'b0);
        drive_beat(1, 302, 1'b1, 1'b0);
        bus.req_addr[AW +: AW] = AW'(303);
        bus.req_data[1]        = 1'b1;
        ce = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.wr_en !== 1'b0 || bus.req_ready !== 2'b00 || bus.busy !== 1'b1 || bus.owner !== 1'b1) begin
                errors++;
                $display("FAIL ce_stall cycle %0d: wr_en=%0b ready=%b busy=%0b owner=%0d, expected 0/00/1/1",
                         c, bus.wr_en, bus.req_ready, bus.busy, bus.owner);
            end
            tick();
        end
        ce = 1'b1;
        drive_beat(1, 303, 1'b1, 1'b0);
        drive_beat(1, 304, 1'b0, 1'b0);
        drive_beat(1, 305, 1'b1, 1'b1);
        bus.req_valid[1] = 1'b0;
        bus.req_last[1]  = 1'b0;
        check_drained("ce_stall");
        checks++;
        if (wr_seen - base != 6) begin
            errors++;
            $display("FAIL ce_write_count: got %0d writes, expected 6", wr_seen - base);
        end
        pulse_swap();
        tick();
    endtask

    task automatic test_reset_mid_frame();
        drive_beat(1, 48, 1'b1, 1'b0);
        drive_beat(1, 49, 1'b1, 1'b0);
        drive_beat(1, 50, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.req_ready, bus.owner, bus.busy} !== '0) begin
            errors++;
            $display("FAIL async_reset: wr_en=%0b addr=%0d data=%0b ready=%b owner=%0d busy=%0b, expected all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.req_ready, bus.owner, bus.busy);
        end
        exp_q.delete();
        bus.req_valid          = 2'b11;
        bus.req_addr[0 +: AW]  = AW'(60);
        bus.req_data[0]        = 1'b1;
        bus.req_addr[AW +: AW] = AW'(70);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (bus.owner !== 1'b0 || bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rearbitrate: owner=%0d ready=%b, expected owner=0 ready=01", bus.owner, bus.req_ready);
        end
        bus.req_last[0] = 1'b1;
        tick();
        bus.req_valid   = 2'b00;
        bus.req_last[0] = 1'b0;
        check_drained("rearb");
        pulse_swap();
        tick();
    endtask

`ifdef FB_SCHED_STATS_EN
    task automatic test_late_frames();
        checks++;
        if (late_frames !== 16'd0) begin
            errors++;
            $display("FAIL late_reset: got %0d, expected 0", late_frames);
        end
        bus.req_valid[0]      = 1'b1;
        bus.req_addr[0 +: AW] = AW'(5);
        tick();
        tick();
        bus.req_valid[0] = 1'b0;
        for (int s = 0; s < 3; s++) begin
            pulse_swap();
            tick();
        end
        checks++;
        if (late_frames !== 16'd3) begin
            errors++;
            $display("FAIL late_count: got %0d, expected 3", late_frames);
        end
        swap = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        swap = 1'b0;
        checks++;
        if (late_frames !== 16'hFFFF) begin
            errors++;
            $display("FAIL late_saturate: got %h, expected ffff", late_frames);
        end
        drive_beat(0, 6, 1'b1, 1'b1);
        bus.req_valid[0] = 1'b0;
        bus.req_last[0]  = 1'b0;
        check_drained("late");
        checks++;
        if (late_frames !== 16'hFFFF) begin
            errors++;
            $display("FAIL late_hold: got %h, expected ffff", late_frames);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame_grant();
        test_wait_swap_rr();
        test_swap_with_last();
        test_ce_stall();
        test_reset_mid_frame();
`ifdef FB_SCHED_STATS_EN
        test_late_frames();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
